dram_frame_reader: RTL and testbench
====================================

# dram_frame_reader

Single-clock AXI4 read master that serves frame-buffer fetch requests from the UDP streaming stage. On a `kick` it reads `read_num` 32-bit words from DRAM, starting at byte address `read_addr`. It splits the request into INCR bursts that never exceed `MAX_BURST` beats and never cross a 4 KB boundary. Returned words go out on `buf_dout`/`buf_we`, which feeds the streaming stage's dataread FIFO write port. `busy` stays high from the accepted kick until the last word has been forwarded.

## Interface
Parameters:
- `MAX_BURST`, default 16: maximum beats per AXI burst. Legal range 1..256.
- `ADDR_WIDTH`, default 32: AXI address width.

Ports:
- `clk`  in  1  single clock. The AXI side and the buffer-write side both run on it.
- `rst`  in  1  reset, asynchronous and active-high.
- `kick`  in  1  one-cycle start pulse. Sampled only in IDLE.
- `read_num`  in  32  word count, sampled with `kick`.
- `read_addr`  in  32  start byte address, sampled with `kick`. Bits [1:0] are ignored and treated as 0.
- `busy`  out  1  high while a request is in progress.
- `buf_dout`  out  32  read data word.
- `buf_we`  out  1  one-cycle strobe for each valid `buf_dout`.
- `rd_err`  out  1  sticky error flag. Cleared only by reset or by an accepted kick.
- `m_axi_araddr`  out  ADDR_WIDTH  burst start address.
- `m_axi_arlen`  out  8  beats minus 1.
- `m_axi_arsize`  out  3  constant 3'b010 (4 bytes).
- `m_axi_arburst`  out  2  constant 2'b01 (INCR).
- `m_axi_arvalid`  out  1  read address valid.
- `m_axi_arready`  in  1  read address ready.
- `m_axi_rdata`  in  32  read data.
- `m_axi_rresp`  in  2  read response.
- `m_axi_rlast`  in  1  last beat of burst.
- `m_axi_rvalid`  in  1  read data valid.
- `m_axi_rready`  out  1  read data ready.

## Operation
- State machine: IDLE, ADDR, DATA.
- **IDLE:**
  - `kick` with `read_num` != 0 latches `addr = {read_addr[31:2],2'b00}` and `remaining = read_num`, clears `rd_err`, then goes to ADDR.
  - `kick` with `read_num` = 0 is ignored: no AXI traffic, `busy` stays 0.
- **ADDR:**
  - `beats = min(remaining, MAX_BURST, 1024 - addr[11:2])`.
  - Drive `arlen = beats-1` and `araddr = addr`.
  - Hold `arvalid` high, with all AR fields stable, until `arready` is seen; then go to DATA.
- **DATA:**
  - `rready` is 1.
  - Each `rvalid` beat forwards `rdata` and increments the beat counter.
  - On the beat where the counter reaches `beats`: `remaining -= beats` and `addr += beats*4` (modulo 2^ADDR_WIDTH). Go to IDLE if `remaining` is 0, else back to ADDR.
- `kick` is ignored outside IDLE.
- Only one burst is ever outstanding.
- Error handling:
  - `rresp` != OKAY on any beat sets `rd_err`. The data is still forwarded.
  - `rlast` not matching the counted final beat sets `rd_err`. Burst termination is always set by the counter, never by `rlast`.
- No back-pressure from the buffer side. The downstream FIFO must have room for `read_num` words before it issues `kick`.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `buf_we`, `rd_err`, `arvalid` and `rready` all 0.
  - `buf_dout`, `araddr` and `arlen` all 0.
- Kick accepted at edge N: `busy` = 1 and `arvalid` = 1 from cycle N+1.
- AR handshake at edge M: `arvalid` = 0 and `rready` = 1 from cycle M+1.
- R handshake at edge K: `buf_dout`/`buf_we` are valid during cycle K+1. Latency is one registered stage.
- Last beat of a burst at edge K with `remaining` > 0: the next `arvalid` rises at K+1.
- Last beat of the request at edge K: `busy` falls at K+1, in the same cycle as the final `buf_we`.
- `busy` is a register equal to (state != IDLE).
- Async reset mid-burst:
  - All outputs return to their reset values immediately.
  - Outstanding R beats arriving after reset release, while in IDLE, are dropped (`rready` = 0). The interconnect is reset together with this block.

## Test plan
- Basic request: `read_addr` 0x100, `read_num` 0x40, `MAX_BURST` 16, zero-wait slave → four bursts at 0x100/0x140/0x180/0x1C0, each with `arlen` 15. Exactly 64 `buf_we` pulses in address order. `busy` falls with the 64th `buf_we`. `rd_err` = 0.
- 4 KB crossing: `read_addr` 0xFF0, `read_num` 8 → two bursts, `arlen` 3 @0xFF0 and `arlen` 3 @0x1000, with 8 words in order.
- Zero length and busy kick: `kick` with `read_num` 0 → no `arvalid`, `busy` stays 0. A second `kick` asserted during an active request is ignored: the beat total equals the first request's count only.
- Back-pressure: `arready` held low for 5 cycles and `rvalid` randomly gapped → AR fields stay stable while `arvalid` is high. `buf_we` count equals `read_num` and data order is preserved.
- Errors: `rresp` = 2'b10 on beat 3, and `rlast` asserted early on beat 2 of a 4-beat burst → `rd_err` = 1 and stays 1 until the next accepted kick. All beats are still forwarded.
- Async reset mid-DATA → `busy`, `buf_we`, `arvalid` and `rready` go to 0 without waiting for a clock edge. A fresh kick after release completes normally.

Source files
------------

// File: rtl/dram_frame_reader.sv
// dram_frame_reader: AXI4 read master that fetches a word run from DRAM and streams it into a buffer write port
module dram_frame_reader #(
    parameter int MAX_BURST  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kick,
    input  logic [31:0]           read_num,
    input  logic [31:0]           read_addr,
    output logic                  busy,
    output logic [31:0]           buf_dout,
    output logic                  buf_we,
    output logic                  rd_err,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, araddr_q, kick_addr_d, next_addr_d;
    logic [31:0]           rem_q, next_rem_d, buf_dout_q;
    logic [8:0]            beats_q, cnt_q, kick_beats_d, next_beats_d;
    logic [7:0]            arlen_q;
    logic                  arvalid_q, rready_q, busy_q, buf_we_q, rd_err_q, last_beat_d;

    // Burst size limited by the words left, MAX_BURST and the distance to the next 4 KB page
    function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] r);
        logic [31:0] room, lim;
        room = 32'd1024 - {22'd0, a[11:2]};
        lim  = (r < 32'(MAX_BURST)) ? r : 32'(MAX_BURST);
        return (lim < room) ? lim[8:0] : room[8:0];
    endfunction

    // Burst sizing for a fresh kick and for the burst following the current one
    always_comb begin
        kick_addr_d  = ADDR_WIDTH'({read_addr[31:2], 2'b00});
        kick_beats_d = burst_beats(kick_addr_d, read_num);
        next_addr_d  = addr_q + ADDR_WIDTH'({beats_q, 2'b00});
        next_rem_d   = rem_q - 32'(beats_q);
        next_beats_d = burst_beats(next_addr_d, next_rem_d);
        last_beat_d  = (cnt_q + 9'd1) == beats_q;
    end

    // Request sequencer: one AR at a time, data beats counted to close each burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            araddr_q   <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            cnt_q      <= '0;
            arlen_q    <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            busy_q     <= 1'b0;
            buf_we_q   <= 1'b0;
            buf_dout_q <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            buf_we_q <= 1'b0;
            case (state_q)
                IDLE: if (kick && read_num != 32'd0) begin
                    addr_q    <= kick_addr_d;
                    rem_q     <= read_num;
                    rd_err_q  <= 1'b0;
                    araddr_q  <= kick_addr_d;
                    beats_q   <= kick_beats_d;
                    arlen_q   <= 8'(kick_beats_d - 9'd1);
                    arvalid_q <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= ADDR;
                end
                ADDR: if (m_axi_arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= DATA;
                end
                DATA: if (m_axi_rvalid) begin
                    buf_we_q   <= 1'b1;
                    buf_dout_q <= m_axi_rdata;
                    cnt_q      <= cnt_q + 9'd1;
                    if (m_axi_rresp != 2'b00 || m_axi_rlast != last_beat_d)
                        rd_err_q <= 1'b1;
                    if (last_beat_d) begin
                        addr_q   <= next_addr_d;
                        rem_q    <= next_rem_d;
                        rready_q <= 1'b0;
                        if (next_rem_d == 32'd0) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            araddr_q  <= next_addr_d;
                            beats_q   <= next_beats_d;
                            arlen_q   <= 8'(next_beats_d - 9'd1);
                            arvalid_q <= 1'b1;
                            state_q   <= ADDR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign buf_dout      = buf_dout_q;
    assign buf_we        = buf_we_q;
    assign rd_err        = rd_err_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
endmodule

// File: tb/tb_dram_frame_reader.sv
// tb_dram_frame_reader: scoreboard bench with a randomized AXI slave and a burst-splitting reference model
module tb_dram_frame_reader;
    logic        clk = 1'b0, rst = 1'b1, kick = 1'b0;
    logic [31:0] read_num = '0, read_addr = '0;
    logic        busy, buf_we, rd_err;
    logic [31:0] buf_dout;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, rready;
    logic        arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;

    int vectors = 0, miscompares = 0;
    int ar_delay_cfg = 0, gap_pct = 0;
    bit inj_rresp = 0, inj_rlast = 0;

    logic [31:0] exp_data[$];
    logic [39:0] exp_ar[$];

    dram_frame_reader #(.MAX_BURST(16), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .kick(kick), .read_num(read_num), .read_addr(read_addr),
        .busy(busy), .buf_dout(buf_dout), .buf_we(buf_we), .rd_err(rd_err),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE_0000;
    endfunction

    // Reference: split the request into bursts by the 16-beat and 4 KB page rules
    task automatic model_push(input logic [31:0] addr, input int unsigned num);
        logic [31:0] a;
        int unsigned rem, b, room;
        a = addr & 32'hFFFF_FFFC;
        rem = num;
        while (rem > 0) begin
            room = 1024 - ((a >> 2) & 1023);
            b = (rem < 16) ? rem : 16;
            if (room < b) b = room;
            exp_ar.push_back({a, 8'(b - 1)});
            for (int i = 0; i < int'(b); i++) exp_data.push_back(mem(a + 4 * i));
            a = a + 4 * b;
            rem = rem - b;
        end
    endtask

    // AXI slave: randomized AR delay and R gaps, data from mem() at the requested address
    initial begin
        logic [31:0] s_addr;
        int s_len, s_beat, s_wait;
        bit s_active, ar_hs, r_hs;
        s_active = 0; s_wait = 0; s_len = 0; s_beat = 0; s_addr = '0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready;
            r_hs = rvalid && rready;
            @(posedge clk); #1;
            if (rst) begin
                s_active = 0; arready = 0; rvalid = 0; rlast = 0; rresp = 0; s_wait = ar_delay_cfg;
            end else begin
                if (ar_hs) begin
                    s_addr = araddr; s_len = int'(arlen); s_beat = 0; s_active = 1; arready = 0; s_wait = ar_delay_cfg;
                end else if (arvalid && !s_active) begin
                    if (s_wait > 0) begin s_wait--; arready = 0; end
                    else arready = 1;
                end
                if (r_hs) begin
                    s_beat++;
                    if (s_beat > s_len) s_active = 0;
                end
                if (s_active) begin
                    rvalid = ($urandom_range(0, 99) >= gap_pct);
                    rdata = mem(s_addr + 4 * s_beat);
                    rresp = (inj_rresp && s_beat == 2) ? 2'b10 : 2'b00;
                    rlast = (s_beat == s_len) || (inj_rlast && s_beat == 1);
                end else begin
                    rvalid = 0; rlast = 0; rresp = 0;
                end
            end
        end
    end

    // Monitor: pops expected words and bursts as the DUT presents them
    initial begin
        logic [31:0] p_addr, e;
        logic [39:0] ea;
        logic [7:0] p_len;
        bit p_pending;
        p_pending = 0; p_addr = '0; p_len = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_pending = 0;
                continue;
            end
            if (buf_we) begin
                if (exp_data.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL extra_buf_we: got word 0x%0h expected none", buf_dout);
                end else begin
                    e = exp_data.pop_front();
                    check("buf_dout", buf_dout, e);
                    check("busy_with_we", busy, exp_data.size() != 0);
                end
            end
            if (arvalid) begin
                if (p_pending) begin
                    check("araddr_stable", araddr, p_addr);
                    check("arlen_stable", arlen, p_len);
                end
                if (arready) begin
                    p_pending = 0;
                    if (exp_ar.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL extra_ar: got addr 0x%0h len %0d expected none", araddr, arlen);
                    end else begin
                        ea = exp_ar.pop_front();
                        check("ar_addr_len", {araddr, arlen}, ea);
                    end
                end else begin
                    p_pending = 1; p_addr = araddr; p_len = arlen;
                end
            end
        end
    end

    task automatic start_req(input logic [31:0] addr, input int unsigned num);
        model_push(addr, num);
        @(posedge clk); #1;
        kick = 1; read_addr = addr; read_num = num;
        @(posedge clk); #1;
        kick = 0;
        check("busy_after_kick", busy, 1);
        check("arvalid_after_kick", arvalid, 1);
        check("rd_err_cleared", rd_err, 0);
    endtask

    task automatic wait_done(input bit exp_err);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++; miscompares++;
            $display("FAIL timeout: busy still 1 after %0d cycles, expected 0", n);
        end
        @(negedge clk);
        check("queues_drained", exp_data.size() + exp_ar.size(), 0);
        check("rd_err", rd_err, exp_err);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_buf_we", buf_we, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_buf_dout", buf_dout, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);
        @(posedge clk); #3;
        rst = 0;

        start_req(32'h100, 64);
        wait_done(0);
        start_req(32'hFF0, 8);
        wait_done(0);
        start_req(32'h1FFE, 5);
        wait_done(0);

        @(posedge clk); #1;
        kick = 1; read_num = 0; read_addr = 32'h40;
        @(posedge clk); #1;
        kick = 0;
        repeat (4) begin
            @(negedge clk);
            check("zero_len_busy", busy, 0);
            check("zero_len_arvalid", arvalid, 0);
        end

        start_req(32'h2000, 20);
        repeat (6) @(posedge clk);
        #1;
        kick = 1; read_num = 7; read_addr = 32'h3000;
        @(posedge clk); #1;
        kick = 0;
        wait_done(0);

        ar_delay_cfg = 5; gap_pct = 40;
        start_req(32'hF80, 40);
        wait_done(0);

        ar_delay_cfg = 0; gap_pct = 0; inj_rresp = 1; inj_rlast = 1;
        start_req(32'h400, 4);
        wait_done(1);
        inj_rresp = 0; inj_rlast = 0;
        repeat (3) begin
            @(negedge clk);
            check("rd_err_sticky", rd_err, 1);
        end
        start_req(32'h500, 3);
        wait_done(0);

        for (int i = 0; i < 20; i++) begin
            ar_delay_cfg = $urandom_range(0, 3);
            gap_pct = $urandom_range(0, 50);
            start_req($urandom & 32'h3FFF, $urandom_range(1, 48));
            wait_done(0);
        end

        ar_delay_cfg = 0; gap_pct = 0;
        start_req(32'h800, 64);
        n = 0;
        while (!buf_we && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("saw_data_before_reset", buf_we, 1);
        @(posedge clk); #3;
        rst = 1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_buf_we", buf_we, 0);
        check("async_rst_arvalid", arvalid, 0);
        check("async_rst_rready", rready, 0);
        exp_data.delete();
        exp_ar.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 0;
        start_req(32'h900, 10);
        wait_done(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
